mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 35 +++
 rtl/mult_div_unit.sv | 175 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and small helpers for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  // MDOp encodings: bit 1 selects divide, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Counter value during the final of the 32 radix-2 steps.
  localparam logic [4:0] MD_LAST_STEP = 5'd31;

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Magnitude of v when treated as signed (sgn=1), otherwise v unchanged.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Operates on magnitudes for 32 radix-2 steps, then applies signs in FIX.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  md_op_e      r_op;
  logic [4:0]  r_cnt;
  logic [63:0] r_work;
  logic [31:0] r_opb;
  logic        r_neg_lo;
  logic        r_neg_hi;
  logic        r_div0;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_launch;
  logic        w_step;
  logic        w_fix;
  logic        w_is_div;
  logic        w_in_signed;
  logic [32:0] w_add_a;
  logic [32:0] w_add_b;
  logic        w_add_cin;
  logic [32:0] w_add_sum;
  logic        w_add_co;
  logic [63:0] w_work_step;
  logic [63:0] w_prod;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_is_div    = op_is_div(r_op);
  assign w_in_signed = op_is_signed(md_op_e'(MDOp));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (Start) w_state_nxt = CALC;
      CALC:    if (r_cnt == MD_LAST_STEP) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs and datapath enables
  always_comb begin
    Busy     = (r_state != IDLE);
    w_launch = (r_state == IDLE) && Start;
    w_step   = (r_state == CALC);
    w_fix    = (r_state == FIX);
  end

  // Shared 33-bit adder: shift-add for multiply, trial subtract for divide.
  // Divide subtracts via ~B + 1; carry-out set means the trial did not borrow.
  always_comb begin
    if (w_is_div) begin
      w_add_a   = r_work[63:31];
      w_add_b   = ~{1'b0, r_opb};
      w_add_cin = 1'b1;
    end else begin
      w_add_a   = {1'b0, r_work[63:32]};
      w_add_b   = {1'b0, r_opb};
      w_add_cin = 1'b0;
    end
    {w_add_co, w_add_sum} = {1'b0, w_add_a} + {1'b0, w_add_b} + {33'd0, w_add_cin};
  end

  // One radix-2 step of the working register
  always_comb begin
    if (w_is_div) begin
      // Restoring divide: remainder in [63:32], quotient bits shift in at [0].
      w_work_step = w_add_co ? {w_add_sum[31:0], r_work[30:0], 1'b1}
                             : {r_work[62:0], 1'b0};
    end else begin
      // Shift-add multiply: multiplier consumed from [0], product grows from the top.
      w_work_step = r_work[0] ? {w_add_sum, r_work[31:1]}
                              : {1'b0, r_work[63:1]};
    end
  end

  // Sign correction and divide-by-zero override applied in FIX
  always_comb begin
    w_prod   = r_neg_lo ? (~r_work + 64'd1) : r_work;
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (w_is_div) begin
      // With a zero divisor every trial succeeds, so [63:32] ends up as |in1|;
      // restoring the dividend sign returns in1 exactly.
      w_res_hi = r_neg_hi ? (~r_work[63:32] + 32'd1) : r_work[63:32];
      if (r_div0) begin
        w_res_lo = DIV0_LO;
      end else begin
        w_res_lo = r_neg_lo ? (~r_work[31:0] + 32'd1) : r_work[31:0];
      end
    end
  end

  // Operand latch, step counter and working register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= MD_MULT;
      r_cnt    <= '0;
      r_work   <= '0;
      r_opb    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_launch) begin
      r_op     <= md_op_e'(MDOp);
      r_cnt    <= '0;
      r_work   <= {32'd0, abs_if(in1, w_in_signed)};
      r_opb    <= abs_if(in2, w_in_signed);
      r_neg_lo <= w_in_signed && (in1[31] ^ in2[31]);
      r_neg_hi <= w_in_signed && in1[31];
      r_div0   <= (in2 == '0);
    end else if (w_step) begin
      r_cnt    <= r_cnt + 5'd1;
      r_work   <= w_work_step;
    end else if (w_fix) begin
      r_cnt    <= '0;
    end
  end

  // HI/LO architectural registers and the Done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_fix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (r_state == IDLE) begin
        if (HiWrite) r_hi <= WriteData;
        if (LoWrite) r_lo <= WriteData;
      end
    end
  end

  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  mult_div_unit #(.DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .in1(in1), .in2(in2), .HiWrite(HiWrite), .LoWrite(LoWrite),
    .WriteData(WriteData), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  time         t_e0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb2;
    longint q;
    longint r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (op)
      2'b00: res = sa * sb2;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb2;
          r   = sa % sb2;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return res;
  endfunction

  // Drive Start for one edge (E0), queue the expected result, then scramble inputs.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    exp_t e;
    @(negedge clk);
    MDOp = op; in1 = a; in2 = b; Start = 1'b1;
    @(posedge clk);
    t_e0  = $time;
    e.tag = tag; e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    #1;
    check({tag, "/busy_e0"}, Busy, 1);
    @(negedge clk);
    Start = 1'b0; MDOp = 2'($urandom); in1 = $urandom; in2 = $urandom;
  endtask

  // Wait (bounded) for Done, check latency, holding behaviour and scoreboard result.
  task automatic finish_op(input string tag);
    bit   seen = 0;
    int   k = 0;
    longint idx;
    exp_t e;
    while (!seen && k < 80) begin
      @(posedge clk); #1;
      k++;
      idx = longint'(($time - 1 - t_e0) / 10);
      if (Done) seen = 1;
      else if (idx == 32) begin
        check({tag, "/busy_e32"}, Busy, 1);
        check({tag, "/hold_e32"}, {Hi, Lo}, {m_hi, m_lo});
      end
    end
    check({tag, "/done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "/latency"}, idx, 33);
      check({tag, "/busy_done"}, Busy, 0);
      check({tag, "/sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, "/hi"}, Hi, e.hi);
        check({e.tag, "/lo"}, Lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
      end
      @(posedge clk); #1;
      check({tag, "/done_pulse"}, Done, 0);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    launch(op, a, b, ehi, elo, tag);
    finish_op(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dones;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rexp;

    reset = 1'b1; Start = 1'b0; MDOp = '0; in1 = '0; in2 = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
    m_hi = '0; m_lo = '0;

    #12;
    check("rst/busy", Busy, 0);
    check("rst/done", Done, 0);
    check("rst/hi", Hi, 0);
    check("rst/lo", Lo, 0);
    @(negedge clk); reset = 1'b0;

    // MTHI / MTLO in IDLE
    @(negedge clk); HiWrite = 1'b1; WriteData = 32'h1234_5678;
    @(negedge clk); HiWrite = 1'b0; LoWrite = 1'b1; WriteData = 32'h9ABC_DEF0;
    @(negedge clk); LoWrite = 1'b0;
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    check("mthi", Hi, m_hi);
    check("mtlo", Lo, m_lo);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
    run_op(MD_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, "divu_by0");
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf");
    run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_neg2");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0");
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         "mult_minmin");
    run_op(MD_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, "divu_max_10");

    // Start and HiWrite while busy are both ignored
    launch(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "busy_ignore");
    repeat (4) @(posedge clk);
    @(negedge clk); Start = 1'b1; MDOp = MD_DIV; in1 = 32'd100; in2 = 32'd3;
    @(negedge clk); Start = 1'b0; HiWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
    @(negedge clk); HiWrite = 1'b0;
    finish_op("busy_ignore");
    repeat (3) @(posedge clk); #1;
    check("busy_ignore/no_second_op", {Busy, Done}, 2'b00);

    // MTHI on the same edge as an accepted Start
    HiWrite = 1'b1; WriteData = 32'hAAAA_5555;
    launch(MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "write_with_start");
    HiWrite = 1'b0;
    m_hi = 32'hAAAA_5555;
    check("write_with_start/hi_e0", Hi, m_hi);
    finish_op("write_with_start");

    // Randomized operations against the reference model
    for (int i = 0; i < 8; i++) begin
      rop  = 2'(i % 4);
      ra   = $urandom;
      rb   = (i == 6) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom;
      rexp = model(rop, ra, rb);
      run_op(rop, ra, rb, rexp[63:32], rexp[31:0], "rand");
    end

    // Asynchronous reset in the middle of CALC
    @(negedge clk); HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'h5A5A_A5A5;
    @(negedge clk); HiWrite = 1'b0; LoWrite = 1'b0;
    m_hi = 32'h5A5A_A5A5; m_lo = 32'h5A5A_A5A5;
    launch(MD_MULT, 32'd7, 32'd9, 32'd0, 32'd63, "aborted");
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort/busy", Busy, 0);
    check("abort/hi", Hi, 0);
    check("abort/lo", Lo, 0);
    check("abort/done", Done, 0);
    sb.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done) dones++;
    end
    check("abort/no_done", dones, 0);
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
